// File: rtl/ram_playback_scheduler.sv
// Read-port sequencer for timed playback of a small RAM.
// Walks read_addr from a latched first address to a latched last address.
// Each word is held for TICK_CYCLES clocks. The sequencer supports loop,
// pause, single-step and stop. Every output comes straight from a flop.
module ram_playback_scheduler #(
  parameter int ADDR_W      = 5,
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              step,
  input  logic              loop,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] read_addr,
  output logic              advance,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              advance_q, advance_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              do_adv;

  // Next-state logic. Commands are resolved in this priority order:
  // stop, then start, then pause, then step, then dwell expiry.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    first_d = first_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    do_adv  = 1'b0;
    if (stop) begin
      // The address is held so the last displayed word stays visible.
      state_d = IDLE;
      cnt_d   = '0;
    end else if (start) begin
      state_d = PLAY;
      addr_d  = first_addr;
      first_d = first_addr;
      last_d  = last_addr;
      cnt_d   = '0;
    end else begin
      case (state_q)
        PLAY: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            do_adv = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PAUSE: begin
          // The dwell counter stays frozen here, including on the exit cycle.
          // A step does not disturb it either.
          if (!pause) begin
            state_d = PLAY;
          end else if (step) begin
            do_adv = 1'b1;
          end
        end
        default: ;
      endcase
      if (do_adv) begin
        // Addresses wrap modulo the depth, so first > last is still a valid range.
        if (addr_q != last_q) begin
          addr_d = addr_q + 1'b1;
        end else if (loop) begin
          addr_d = first_q;
        end else begin
          state_d = DONE;
        end
      end
    end
    advance_d = do_adv;
    busy_d    = (state_d == PLAY) || (state_d == PAUSE);
    done_d    = (state_d == DONE);
  end

  // State and output registers. Reset takes effect without waiting for a clock.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      first_q   <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      advance_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      first_q   <= first_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      advance_q <= advance_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign read_addr = addr_q;
  assign advance   = advance_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_ram_playback_scheduler.sv
// Directed and randomized checks of ram_playback_scheduler (TICK_CYCLES=4).
// The outputs are compared each cycle against a behavioural playback model.
module tb_ram_playback_scheduler;

  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int TICK  = 4;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0, stop = 1'b0, pause = 1'b0, step = 1'b0, loop = 1'b0;
  logic [AW-1:0] first_addr = '0, last_addr = '0;
  logic [AW-1:0] read_addr;
  logic          advance, busy, done;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  // Model state. States are 0=idle, 1=play, 2=pause, 3=done.
  int m_state, m_addr, m_first, m_last, m_elapsed;
  bit m_adv;

  ram_playback_scheduler #(.ADDR_W(AW), .TICK_CYCLES(TICK)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .stop(stop),
    .pause(pause), .step(step), .loop(loop), .first_addr(first_addr),
    .last_addr(last_addr), .read_addr(read_addr), .advance(advance),
    .busy(busy), .done(done), .state(state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_addr = 0; m_first = 0; m_last = 0; m_elapsed = 0; m_adv = 0;
  endtask

  // Move the show on by one word. At the end of the range, either reload or finish.
  task automatic model_next_word();
    m_adv = 1;
    if (m_addr != m_last) m_addr = (m_addr + 1) % DEPTH;
    else if (loop) m_addr = m_first;
    else m_state = 3;
  endtask

  // One clock edge of playback, applied from the current input values.
  task automatic model_edge();
    m_adv = 0;
    if (!reset) begin
      model_reset();
    end else if (stop) begin
      m_state = 0; m_elapsed = 0;
    end else if (start) begin
      m_first = int'(first_addr); m_last = int'(last_addr);
      m_addr = m_first; m_elapsed = 0; m_state = 1;
    end else if (m_state == 1) begin
      if (pause) m_state = 2;
      else begin
        m_elapsed++;
        if (m_elapsed == TICK) begin
          m_elapsed = 0;
          model_next_word();
        end
      end
    end else if (m_state == 2) begin
      if (!pause) m_state = 1;
      else if (step) model_next_word();
    end
  endtask

  task automatic compare_all(input string tag);
    logic [9:0] obs, exp;
    obs = {read_addr, state, advance, busy, done};
    exp = {m_addr[AW-1:0], m_state[1:0], m_adv, (m_state == 1 || m_state == 2), (m_state == 3)};
    check(tag, {22'd0, obs}, {22'd0, exp});
  endtask

  task automatic cycle(input string tag);
    @(posedge CLOCK_50);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic pulse_start(input logic [AW-1:0] f, input logic [AW-1:0] l, input logic lp);
    first_addr = f; last_addr = l; loop = lp; start = 1'b1;
    cycle("start");
    start = 1'b0;
  endtask

  int exp_seq[5] = '{31, 0, 1, 30, 31};
  int seen;

  initial begin
    model_reset();
    #1;
    compare_all("reset_t0");
    check("reset_addr", read_addr, 0);
    repeat (2) cycle("reset_hold");
    reset = 1'b1;
    cycle("idle");

    // A range that plays once and stops on its last word
    pulse_start(5'd3, 5'd5, 1'b0);
    check("t2_first", read_addr, 3);
    repeat (12) cycle("t2_play");
    check("t2_state", state, 2'b11);
    check("t2_done", done, 1);
    check("t2_addr", read_addr, 5);

    // A looping range that crosses the top of the address space
    pulse_start(5'd30, 5'd1, 1'b1);
    seen = 0;
    for (int i = 0; i < 5 * TICK; i++) begin
      cycle("t3_loop");
      if (advance === 1'b1 && seen < 5) begin
        check("t3_seq", read_addr, exp_seq[seen]);
        seen++;
      end
    end
    check("t3_count", seen, 5);
    check("t3_busy", busy, 1);

    // Pause, a single step, then resume
    pulse_start(5'd3, 5'd10, 1'b0);
    repeat (2) cycle("t4_run");
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step = (i == 5);
      cycle("t4_pause");
      if (i == 4) check("t4_hold", read_addr, 3);
    end
    step = 1'b0;
    check("t4_step", read_addr, 4);
    pause = 1'b0;
    repeat (3) cycle("t4_resume");
    check("t4_resume_addr", read_addr, 5);

    // stop wins over start in the same cycle
    stop = 1'b1; start = 1'b1; first_addr = 5'd12;
    cycle("t5");
    stop = 1'b0; start = 1'b0;
    check("t5_state", state, 2'b00);
    check("t5_addr", read_addr, 5);

    // Range inputs are ignored until the next start
    pulse_start(5'd8, 5'd9, 1'b0);
    first_addr = 5'd20; last_addr = 5'd22;
    repeat (8) cycle("t6_play");
    check("t6_done_addr", read_addr, 9);
    check("t6_state", state, 2'b11);
    start = 1'b1;
    cycle("t6_restart");
    start = 1'b0;
    check("t6_new", read_addr, 20);

    // One-word range
    pulse_start(5'd7, 5'd7, 1'b0);
    repeat (TICK) cycle("one_word");
    check("one_word_done", done, 1);

    // Reset applied between clock edges
    repeat (3) cycle("pre_async");
    reset = 1'b0;
    model_reset();
    #1;
    compare_all("async_reset");
    check("async_state", state, 2'b00);
    cycle("async_hold");
    reset = 1'b1;

    // Random commands
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 149) == 0);
      step  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if ($urandom_range(0, 49) == 0) loop = ~loop;
      first_addr = AW'($urandom);
      last_addr  = AW'($urandom);
      cycle("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
